// File: rtl/mem_write_checker.sv
// Checks a DUT's stream of memory stores against a programmed table of expected
// (address, data) writes, in order or in any order, with a run-cycle timeout.
module mem_write_checker #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    parameter int ORDERED = 1,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CW-1:0]     cfg_num,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IW-1:0]     fail_index,
    output logic [CW-1:0]     match_count,
    output logic [31:0]       cycle_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_DATA    = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    logic [ADDR_W-1:0] tab_addr_q [DEPTH];
    logic [DATA_W-1:0] tab_data_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    num_q, num_d;
    logic [CW-1:0]    match_q, match_d;
    logic [31:0]      cycle_q, cycle_d;
    logic [DEPTH-1:0] hit_q, hit_d;
    logic [1:0]       code_q, code_d;
    logic [IW-1:0]    fidx_q, fidx_d;

    logic             any_addr, any_eq;
    logic [IW-1:0]    first_addr, first_eq;
    logic [IW-1:0]    exp_idx;

    // Table contents survive reset so a check can be rerun without reloading.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q != S_RUN)) begin
            tab_addr_q[cfg_idx] <= cfg_addr;
            tab_data_q[cfg_idx] <= cfg_data;
        end
    end

    // Descending scan so the lowest-index unhit candidate wins.
    always_comb begin
        any_addr   = 1'b0;
        any_eq     = 1'b0;
        first_addr = '0;
        first_eq   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < num_q) && !hit_q[i] && (tab_addr_q[i] == alu_result)) begin
                any_addr   = 1'b1;
                first_addr = IW'(i);
                if (tab_data_q[i] == write_data) begin
                    any_eq   = 1'b1;
                    first_eq = IW'(i);
                end
            end
        end
    end

    assign exp_idx = IW'(match_q);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        match_d = match_q;
        cycle_d = cycle_q;
        hit_d   = hit_q;
        code_d  = code_q;
        fidx_d  = fidx_q;
        if (state_q == S_RUN) begin
            cycle_d = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
            if (match_q == num_q) begin
                state_d = S_PASS;
            end else begin
                if (mem_write) begin
                    if (ORDERED != 0) begin
                        if (tab_addr_q[exp_idx] == alu_result) begin
                            if (tab_data_q[exp_idx] == write_data) begin
                                match_d = match_q + CW'(1);
                            end else begin
                                state_d = S_FAIL;
                                code_d  = FC_DATA;
                                fidx_d  = exp_idx;
                            end
                        end
                    end else if (any_eq) begin
                        hit_d[first_eq] = 1'b1;
                        match_d         = match_q + CW'(1);
                    end else if (any_addr) begin
                        state_d = S_FAIL;
                        code_d  = FC_DATA;
                        fidx_d  = first_addr;
                    end
                end
                // A store completing the table on the timeout cycle still passes.
                if ((state_d == S_RUN) && (cycle_d >= 32'(TIMEOUT)) && (match_d != num_q)) begin
                    state_d = S_FAIL;
                    code_d  = FC_TIMEOUT;
                end
            end
        end else if (start) begin
            state_d = S_RUN;
            num_d   = (cfg_num > CW'(DEPTH)) ? CW'(DEPTH) : cfg_num;
            match_d = '0;
            cycle_d = '0;
            hit_d   = '0;
            code_d  = FC_NONE;
            fidx_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            match_q <= '0;
            cycle_q <= '0;
            hit_q   <= '0;
            code_q  <= FC_NONE;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            match_q <= match_d;
            cycle_q <= cycle_d;
            hit_q   <= hit_d;
            code_q  <= code_d;
            fidx_q  <= fidx_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass        = (state_q == S_PASS);
    assign fail_code   = code_q;
    assign fail_index  = fidx_q;
    assign match_count = match_q;
    assign cycle_count = cycle_q;

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, write-data width. ADDR_W, default 32, address width. DEPTH, default 4, number of expected-write entries. TIMEOUT, default 1000, run-cycle limit. ORDERED, default 1, 1 means in-order matching and 0 means any-order matching.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- cfg_we  in  1  expected-table write strobe
- cfg_idx  in  IW=$clog2(DEPTH)  table index
- cfg_addr  in  ADDR_W  expected address
- cfg_data  in  DATA_W  expected data
- cfg_num  in  CW=$clog2(DEPTH+1)  entries in use, sampled on start
- start  in  1  begin check
- mem_write  in  1  DUT store strobe
- alu_result  in  ADDR_W  DUT store address
- write_data  in  DATA_W  DUT store data
- busy  out  1  state is RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state is PASS
- fail_code  out  2  0 none, 1 data mismatch, 2 timeout
- fail_index  out  IW  entry that caused the mismatch
- match_count  out  CW  entries matched so far
- cycle_count  out  32  cycles spent in RUN, saturating

Function
REQ-003 The FSM SHALL have states IDLE, RUN, PASS and FAIL, all sampled on the rising edge of clk.
REQ-004 A cfg_we pulse SHALL write entry[cfg_idx] in the next cycle only in IDLE, PASS or FAIL; cfg_we in RUN SHALL be ignored.
REQ-005 start in IDLE, PASS or FAIL SHALL latch cfg_num, clear match_count, cycle_count, the hit mask and fail_code, and enter RUN; start in RUN SHALL be ignored.
REQ-006 cfg_num values of 0 or greater than DEPTH SHALL be clamped to 0 and DEPTH respectively; a value of 0 SHALL go from RUN to PASS on the first RUN cycle.
REQ-007 In RUN, cycle_count SHALL increment by 1 every cycle and saturate at 2^32-1.
REQ-008 In RUN, a cycle with mem_write=0 SHALL change only cycle_count.
REQ-009 ORDERED=1, store to entry[match_count] address:
- data equal: match_count increments.
- data different: enter FAIL with fail_code=1 and fail_index=match_count.
- stores to any other address: ignored.
REQ-010 ORDERED=0, store address equals the address of one or more unhit entries below num:
- if any such entry has equal data: the lowest-index one is marked hit and match_count increments.
- otherwise: enter FAIL with fail_code=1 and fail_index set to the lowest such entry.
REQ-011 ORDERED=0: stores matching only already-hit entries SHALL be ignored.
REQ-012 When match_count reaches num, the FSM SHALL enter PASS on the following edge, giving one cycle of latency from the last matching store to pass=1.
REQ-013 When cycle_count reaches TIMEOUT while in RUN and not matching, the FSM SHALL enter FAIL with fail_code=2.
REQ-014 A final match and a timeout in the same cycle SHALL resolve to PASS.
REQ-015 PASS and FAIL SHALL hold all outputs until the next start or reset; mem_write SHALL be ignored in those states.
REQ-016 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-017 reset=0 SHALL asynchronously force state IDLE and set busy, done, pass, fail_code, fail_index, match_count and cycle_count to 0.
REQ-018 Expected-table contents SHALL NOT be reset; reset asserted during RUN SHALL abort the check to IDLE immediately with no PASS or FAIL.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- ORDERED=1, entries {0x64:7, 0x68:45600}, num=2, stores 0x60:1, 0x64:7, 0x68:45600 -> match_count 0,1,2; pass=1 one cycle after the last store; fail_code=0.
- ORDERED=1, same table, store 0x64:8 -> fail_code=1, fail_index=0, done=1, pass=0.
- ORDERED=0, same table, stores 0x68:45600 then 0x64:7 -> PASS; a repeat store 0x68:45600 between them leaves match_count=1.
- TIMEOUT=20, num=1, no stores -> FAIL with fail_code=2 and cycle_count=20; a final match on the timeout cycle yields PASS instead.
- reset=0 mid-RUN, asynchronous between edges -> outputs 0 immediately; after release, start with the same table passes without reloading.
- num=0 -> pass=1 two cycles after start; cfg_we during RUN does not alter the table.
